alu_arbiter: RTL
================

// Module: alu_arbiter
// PURPOSE
//  Shares the single 8-bit ALU (FORWARD/ADD/AND/OR, 3-bit SELECT, ZERO flag) between two requesters.
//  Requester 0 is the CPU execute stage; requester 1 is the address/offset path of the memory subsystem.
//  Arbitrates round-robin, drives ALU DATA1/DATA2/SELECT, waits out ALU settle time, captures RESULT/ZERO.
//  Returns one tagged response at a time through a valid/ready handshake.
// PARAMETERS
//  WIDTH          8   operand/result width; matches ALU DATA1/DATA2/RESULT
//  SETTLE_CYCLES  2   clock cycles the ALU inputs are held before RESULT/ZERO are sampled; legal range >=1
//  OP_MAX         3   highest legal SELECT code (000 FORWARD, 001 ADD, 010 AND, 011 OR)
// PORTS
//  CLK         in   1      clock; all state changes on rising edge
//  RESET       in   1      asynchronous, active-high reset
//  REQ0_VALID  in   1      requester 0 has an operation
//  REQ0_READY  out  1      requester 0 operation accepted this cycle
//  REQ0_OP     in   3      requester 0 ALU select code
//  REQ0_A      in   WIDTH  requester 0 operand -> ALU DATA1
//  REQ0_B      in   WIDTH  requester 0 operand -> ALU DATA2
//  REQ1_*      same as REQ0_* for requester 1
//  ALU_DATA1   out  WIDTH  to ALU DATA1
//  ALU_DATA2   out  WIDTH  to ALU DATA2
//  ALU_SELECT  out  3      to ALU SELECT
//  ALU_RESULT  in   WIDTH  from ALU RESULT
//  ALU_ZERO    in   1      from ALU ZERO
//  RSP_VALID   out  1      response available
//  RSP_READY   in   1      consumer takes response
//  RSP_ID      out  1      requester that owns the response
//  RSP_RESULT  out  WIDTH  captured ALU result
//  RSP_ZERO    out  1      captured ALU zero flag
//  RSP_ERR     out  1      op code > OP_MAX; no ALU issue
//  BUSY        out  1      state != IDLE
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, count=0, LAST_GRANT=1.
//   All outputs 0: ALU_* and RSP_* 0, BUSY 0, REQx_READY 0.
//  States: IDLE -> EXEC -> RESP -> IDLE; IDLE -> RESP directly for an illegal op.
//  IDLE:
//   - REQx_READY is combinational: high only for the arbitration winner, only in IDLE; never both high.
//   - Winner: sole valid requester; if both valid, requester != LAST_GRANT.
//   - On accept edge (VALID&READY): latch ID/op/operands, LAST_GRANT=ID.
//   - Legal op: drive ALU_DATA1=A, ALU_DATA2=B, ALU_SELECT=OP; count=0; go EXEC.
//   - Illegal op (OP>OP_MAX): ALU_* unchanged; RSP_RESULT=0, RSP_ZERO=0, RSP_ERR=1; go RESP.
//  EXEC:
//   - ALU_* held constant; count increments each edge.
//   - Edge with count==SETTLE_CYCLES-1: RSP_RESULT=ALU_RESULT, RSP_ZERO=ALU_ZERO, RSP_ERR=0; go RESP.
//   - Latency: accept at edge N -> RSP_VALID high after edge N+SETTLE_CYCLES (illegal op: after edge N+1).
//  RESP:
//   - RSP_VALID=1; all RSP_* stable until RSP_READY sampled high, then IDLE, RSP_VALID=0.
//   - No new accept can occur on the RSP_READY edge; earliest next accept is the following edge.
//  ALU_* hold last issued values outside EXEC (no toggling while idle).
//  A requester holding VALID while not granted must keep OP/A/B stable; the block never drops a pending request.
//  RESET asserted mid-EXEC/RESP: operation and response discarded, no RSP_VALID pulse.
//  Arithmetic is done by the ALU only: ADD wraps modulo 2^WIDTH, carry discarded; no width extension here.
// TESTING
//  1. Reset, REQ0 ADD A=8'h05 B=8'h03 -> REQ0_READY at edge0; RSP_VALID after edge2, ID=0 RESULT=08 ZERO=0 ERR=0.
//  2. REQ1 ADD A=8'hFF B=8'h01 -> RSP RESULT=00 ZERO=1 (wrap); ALU_SELECT=001 held through EXEC.
//  3. Both valid continuously (REQ0 AND F0&0F, REQ1 OR F0|0F), RSP_READY=1 -> grants 0,1,0,1; RESULT 00/FF alternating.
//  4. REQ0_OP=3'b101 -> RSP after 1 cycle, ERR=1, RESULT=00; ALU_SELECT unchanged.
//  5. Hold RSP_READY=0 for 5 cycles with REQ1 valid -> RSP_* stable, REQ1_READY=0 until one edge after RSP_READY=1.
//  6. Assert RESET mid-EXEC -> all outputs 0 immediately; after release, REQ1 and REQ0 both valid -> REQ0 granted first.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one external ALU between two requesters with tagged valid/ready responses
// Ports: clk/reset (async, active-high); req0_*/req1_* valid/ready/op/a/b request channels;
//   alu_data1/alu_data2/alu_select drive the ALU, alu_result/alu_zero are sampled back;
//   rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_zero/rsp_err response channel; busy = not idle.
module alu_arbiter #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int OP_MAX        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] alu_data1,
  output logic [WIDTH-1:0] alu_data2,
  output logic [2:0]       alu_select,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy
);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, next;
  logic last_grant, accept, win, illegal, settled;
  logic [CW-1:0] count;
  logic [2:0] op;
  logic [WIDTH-1:0] a, b;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  // ready is gated by reset so nothing is offered while reset is held
  always_comb begin
    req0_ready = (state == IDLE) & ~reset & req0_valid & (~req1_valid | last_grant);
    req1_ready = (state == IDLE) & ~reset & req1_valid & (~req0_valid | ~last_grant);
    accept     = req0_ready | req1_ready;
    win        = req1_ready;
    op         = win ? req1_op : req0_op;
    a          = win ? req1_a : req0_a;
    b          = win ? req1_b : req0_b;
    illegal    = op > 3'(OP_MAX);
    settled    = count == CW'(SETTLE_CYCLES - 1);
    next       = state == IDLE ? (accept ? (illegal ? RESP : EXEC) : IDLE) :
                 state == EXEC ? (settled ? RESP : EXEC) :
                 (rsp_ready ? IDLE : RESP);
    rsp_valid  = state == RESP;
    busy       = state != IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      last_grant <= 1'b1;
      count      <= '0;
      alu_data1  <= '0;
      alu_data2  <= '0;
      alu_select <= '0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        rsp_id     <= win;
        last_grant <= win;
        if (illegal) begin
          rsp_result <= '0;
          rsp_zero   <= 1'b0;
          rsp_err    <= 1'b1;
        end else begin
          alu_data1  <= a;
          alu_data2  <= b;
          alu_select <= op;
          count      <= '0;
        end
      end
      if (state == EXEC) begin
        count <= count + CW'(1);
        if (settled) begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_err    <= 1'b0;
        end
      end
    end
endmodule
